// File: rtl/pc_sequencer.sv
// pc_sequencer
// Instruction-sequencing end of the control interface. It holds the
// fetch/execute state bit, the program counter, the instruction register and
// a bounded return-address stack. It gives state and opcode to the control
// decoder and takes back the decoder's PS (PC select) and IL (instruction
// load) strobes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (sampled on clk)
//   instr_in   instruction word read from instruction memory at address pc
//   imem_valid instr_in is valid this cycle
//   IL         instruction load strobe (used in FETCH only)
//   PS         PC select: 00 hold, 01 increment, 10 branch, 11 return
//              (used in EXECUTE only)
//   state      0 = fetch, 1 = execute
//   opcode     ir[15:12]
//   ir         instruction register
//   pc         program counter, also the instruction memory address
//   sp         number of valid return-stack entries
//   stk_ovf    sticky flag: a call was attempted while the stack was full
//   stk_unf    sticky flag: a return was attempted while the stack was empty
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int OFFSET_W    = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [15:0]                    instr_in,
  input  logic                           imem_valid,
  input  logic                           IL,
  input  logic [1:0]                     PS,
  output logic                           state,
  output logic [3:0]                     opcode,
  output logic [15:0]                    ir,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                           stk_ovf,
  output logic                           stk_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  // The index width is at least one bit, so a depth-1 stack still has a
  // legal index.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] DEPTH_C = SP_W'(STACK_DEPTH);
  localparam logic [3:0] OP_CALL = 4'b1101;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t              state_r;
  logic [15:0]         ir_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [SP_W-1:0]     sp_r;
  logic                ovf_r;
  logic                unf_r;
  // The array is rounded up to a power of two so any sp value used as an
  // index stays in range. Only entries 0..STACK_DEPTH-1 are ever written.
  logic [ADDR_W-1:0]   stack_r [0:(2**IDX_W)-1];

  logic signed [OFFSET_W-1:0] off_raw_s;
  logic [ADDR_W-1:0]   off_s;
  logic [ADDR_W-1:0]   pc1_s;
  logic [ADDR_W-1:0]   target_s;
  logic [SP_W-1:0]     sp_dec_s;
  logic [ADDR_W-1:0]   pc_nxt_s;
  logic [SP_W-1:0]     sp_nxt_s;
  logic                push_s;
  logic                ovf_set_s;
  logic                unf_set_s;

  // The offset field is signed. The cast to ADDR_W sign-extends it, and all
  // PC sums then wrap modulo 2^ADDR_W.
  assign off_raw_s = $signed(ir_r[OFFSET_W-1:0]);
  assign off_s     = ADDR_W'(off_raw_s);
  assign pc1_s     = pc_r + ADDR_W'(1);
  assign target_s  = pc1_s + off_s;
  assign sp_dec_s  = sp_r - SP_W'(1);

  // Next PC/stack action for an EXECUTE cycle. A call overrides PS.
  always_comb begin
    pc_nxt_s  = pc_r;
    sp_nxt_s  = sp_r;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (ir_r[15:12] == OP_CALL) begin
      if (sp_r < DEPTH_C) begin
        push_s   = 1'b1;
        sp_nxt_s = sp_r + SP_W'(1);
        pc_nxt_s = target_s;
      end else begin
        // A full stack turns the call into a plain step.
        ovf_set_s = 1'b1;
        pc_nxt_s  = pc1_s;
      end
    end else begin
      case (PS)
        2'b11: begin
          if (sp_r != {SP_W{1'b0}}) begin
            pc_nxt_s = stack_r[sp_dec_s[IDX_W-1:0]];
            sp_nxt_s = sp_dec_s;
          end else begin
            unf_set_s = 1'b1;
            pc_nxt_s  = pc1_s;
          end
        end
        2'b10:   pc_nxt_s = target_s;
        2'b01:   pc_nxt_s = pc1_s;
        default: pc_nxt_s = pc_r;
      endcase
    end
  end

  // Fetch/execute sequencer with the PC, IR, stack pointer and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 16'h0000;
      sp_r    <= {SP_W{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_valid) begin
            // If IL is low, the stale ir is executed.
            if (IL) begin
              ir_r <= instr_in;
            end else begin
              ir_r <= ir_r;
            end
            state_r <= EXEC;
          end else begin
            state_r <= FETCH;
          end
        end
        EXEC: begin
          state_r <= FETCH;
          pc_r    <= pc_nxt_s;
          sp_r    <= sp_nxt_s;
          if (push_s) begin
            stack_r[sp_r[IDX_W-1:0]] <= pc1_s;
          end else begin
            stack_r[sp_r[IDX_W-1:0]] <= stack_r[sp_r[IDX_W-1:0]];
          end
          ovf_r <= ovf_r | ovf_set_s;
          unf_r <= unf_r | unf_set_s;
        end
        default: state_r <= FETCH;
      endcase
    end
  end

  assign state   = state_r;
  assign ir      = ir_r;
  assign opcode  = ir_r[15:12];
  assign pc      = pc_r;
  assign sp      = sp_r;
  assign stk_ovf = ovf_r;
  assign stk_unf = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. A behavioural model (queue-based stack, plain
// arithmetic PC) runs alongside the DUT, and a negedge process compares
// every output each cycle. Directed sequences pin the model with hand-computed
// values. A randomized phase follows.
module tb_pc_sequencer;

  localparam logic [7:0] RST_PC = 8'h10;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        imem_valid;
  logic        IL;
  logic [1:0]  PS;
  logic        state;
  logic [3:0]  opcode;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic [2:0]  sp;
  logic        stk_ovf;
  logic        stk_unf;

  pc_sequencer #(
    .ADDR_W(8), .OFFSET_W(8), .STACK_DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imem_valid(imem_valid),
    .IL(IL), .PS(PS), .state(state), .opcode(opcode), .ir(ir), .pc(pc),
    .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // behavioural model state
  bit         m_exec;
  logic [15:0] m_ir;
  logic [7:0] m_pc;
  logic [7:0] stk[$];
  bit         m_ovf;
  bit         m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: one step of the spec's fetch/execute rules per clock edge
  always @(posedge clk) begin
    logic [7:0] pc1;
    logic [7:0] off;
    pc1 = m_pc + 8'd1;
    off = m_ir[7:0];  // OFFSET_W == ADDR_W: sign extension is the identity here
    if (!rst_n) begin
      m_exec = 1'b0; m_pc = RST_PC; m_ir = 16'h0000;
      stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!m_exec) begin
      if (imem_valid) begin
        if (IL) m_ir = instr_in;
        m_exec = 1'b1;
      end
    end else begin
      m_exec = 1'b0;
      if (m_ir[15:12] == 4'hD) begin
        if (stk.size() < DEPTH) begin
          stk.push_back(pc1);
          m_pc = pc1 + off;
        end else begin
          m_ovf = 1'b1; m_pc = pc1;
        end
      end else if (PS == 2'b11) begin
        if (stk.size() > 0) m_pc = stk.pop_back();
        else begin
          m_unf = 1'b1; m_pc = pc1;
        end
      end else if (PS == 2'b10) m_pc = pc1 + off;
      else if (PS == 2'b01) m_pc = pc1;
    end
  end

  // compare process: all outputs against the model, every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", state, m_exec);
      check("ir", ir, m_ir);
      check("opcode", opcode, m_ir[15:12]);
      check("pc", pc, m_pc);
      check("sp", sp, stk.size());
      check("stk_ovf", stk_ovf, m_ovf);
      check("stk_unf", stk_unf, m_unf);
    end
  end

  task automatic cyc(input logic r, input logic v, input logic il,
                     input logic [1:0] ps, input logic [15:0] ins);
    @(negedge clk);
    rst_n = r; imem_valid = v; IL = il; PS = ps; instr_in = ins;
    @(posedge clk);
    #1;
  endtask

  // fetch ins, then execute it with PS = ps
  task automatic run(input logic [15:0] ins, input logic [1:0] ps);
    cyc(1'b1, 1'b1, 1'b1, 2'b00, ins);
    cyc(1'b1, 1'b1, 1'b1, ps, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; imem_valid = 1'b1; IL = 1'b1; PS = 2'b01; instr_in = 16'h0123;
    @(posedge clk);
    #1;
    check("rst_pc", pc, 8'h10);
    check("rst_state", state, 1'b0);
    check("rst_ir", ir, 16'h0000);
    check("rst_sp", sp, 3'd0);
    cmp_en = 1'b1;

    // 1: fetch then execute an increment
    cyc(1'b1, 1'b1, 1'b1, 2'b01, 16'h0123);
    check("t1_ir", ir, 16'h0123);
    check("t1_state", state, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 2'b01, 16'h0123);
    check("t1_pc", pc, 8'h11);
    check("t1_state2", state, 1'b0);

    // 2: branch with negative offset and wrap
    run(16'hB0F0, 2'b10);          // 0x12 - 16 = 0x02
    check("t2_pc02", pc, 8'h02);
    run(16'hB0FC, 2'b10);          // 0x03 - 4 = 0xFF
    check("t2_pcFF", pc, 8'hFF);
    check("t2_model", m_pc, 8'hFF);
    run(16'h0000, 2'b01);
    check("t2_wrap", pc, 8'h00);

    // 3: call and return
    run(16'hB01F, 2'b10);          // 0x01 + 0x1F = 0x20
    check("t3_pc20", pc, 8'h20);
    run(16'hD005, 2'b00);
    check("t3_call_pc", pc, 8'h26);
    check("t3_call_sp", sp, 3'd1);
    run(16'h0000, 2'b11);
    check("t3_ret_pc", pc, 8'h21);
    check("t3_ret_sp", sp, 3'd0);

    // 4: overflow then underflow
    for (int i = 0; i < 5; i++) run(16'hD001, 2'b01);
    check("t4_ovf_pc", pc, 8'h2A);
    check("t4_ovf_sp", sp, 3'd4);
    check("t4_ovf", stk_ovf, 1'b1);
    check("t4_model_sp", stk.size(), 4);
    begin
      logic [7:0] exp_ret [5];
      exp_ret = '{8'h28, 8'h26, 8'h24, 8'h22, 8'h23};
      for (int i = 0; i < 5; i++) begin
        run(16'h0000, 2'b11);
        check("t4_ret_pc", pc, exp_ret[i]);
      end
    end
    check("t4_unf", stk_unf, 1'b1);
    check("t4_ovf_kept", stk_ovf, 1'b1);

    // 5: fetch stall
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 2'b10, 16'h1234);
      check("t5_state", state, 1'b0);
      check("t5_pc", pc, 8'h23);
      check("t5_ir", ir, 16'h0000);
    end
    cyc(1'b1, 1'b1, 1'b1, 2'b10, 16'h1234);
    check("t5_load", ir, 16'h1234);
    cyc(1'b1, 1'b1, 1'b1, 2'b01, 16'h0000);
    check("t5_pc24", pc, 8'h24);

    // 6: reset in EXECUTE during a call with sp=2
    run(16'hD001, 2'b00);
    run(16'hD001, 2'b00);
    check("t6_sp2", sp, 3'd2);
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 16'hD001);
    check("t6_exec", state, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'b00, 16'h0000);
    check("t6_pc", pc, 8'h10);
    check("t6_sp", sp, 3'd0);
    check("t6_state", state, 1'b0);
    check("t6_ovf", stk_ovf, 1'b0);
    check("t6_unf", stk_unf, 1'b0);

    // randomized phase, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom());
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hD;
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 9) != 0),
          2'($urandom_range(0, 3)),
          ins);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing end of the control interface. Holds the fetch/execute state bit, program counter (PC), instruction register (IR) and a return-address stack.
- Supplies state and opcode to the control decoder, and consumes the decoder's PS (PC select) and IL (instruction load) strobes.
- Implements call (opcode 1101) and return (PS=11) with a bounded hardware stack.

Parameters:
- ADDR_W, 8: PC and stack entry width.
- OFFSET_W, 8: branch/jump offset width, taken from IR[OFFSET_W-1:0], signed; OFFSET_W <= ADDR_W is required.
- STACK_DEPTH, 4: number of return-stack entries, >= 1.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- instr_in  in  16  instruction word from instruction memory at address pc.
- imem_valid  in  1  instr_in is valid this cycle.
- IL  in  1  instruction load strobe from the decoder.
- PS  in  2  PC select: 00 hold, 01 increment, 10 branch/jump, 11 return.
- state  out  1  0 = fetch, 1 = execute.
- opcode  out  4  IR[15:12].
- ir  out  16  instruction register.
- pc  out  ADDR_W  program counter; drives instruction memory address.
- sp  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stk_ovf  out  1  sticky: call attempted with stack full.
- stk_unf  out  1  sticky: return attempted with stack empty.

Behaviour:
- Reset: one clk edge with rst_n=0 sets state=0, pc=RESET_PC, ir=16'h0000, sp=0, stk_ovf=0, stk_unf=0. Stack contents are don't-care. Reset takes priority over all other activity, including mid-execute and mid-wait.
- All outputs are registered. opcode is a combinational slice of the ir register.
- Notation: off = sign-extend(ir[OFFSET_W-1:0]) to ADDR_W; pc1 = pc+1. All PC arithmetic is modulo 2^ADDR_W, so 0xFF+1 -> 0x00 wraps silently.
- FETCH (state=0):
  - If imem_valid=1 and IL=1: ir <= instr_in, state <= 1.
  - If imem_valid=0: ir and state are held; the block stays in FETCH indefinitely.
  - IL=0 with imem_valid=1: ir is held, state <= 1. A decoder fault path; the stale ir is executed.
  - pc is held in FETCH regardless of PS.
- EXECUTE (state=1): state <= 0 always, so execute is exactly one cycle. The pc update is chosen in this priority:
  1. Call, ir[15:12]=4'b1101, overrides PS.
     - sp < STACK_DEPTH: stack[sp] <= pc1, sp <= sp+1, pc <= pc1+off.
     - sp == STACK_DEPTH: no push, stk_ovf <= 1, pc <= pc1 (call becomes a no-op).
  2. PS=11, return.
     - sp > 0: pc <= stack[sp-1], sp <= sp-1.
     - sp == 0: stk_unf <= 1, pc <= pc1.
  3. PS=10: pc <= pc1+off.
  4. PS=01: pc <= pc1.
  5. PS=00: pc held.
- The stack is LIFO, entries 0..sp-1 are valid, and it does not wrap.
- Sticky flags clear only on reset.
- Throughput: one instruction per two cycles with imem_valid held high. Each cycle with imem_valid=0 in FETCH adds one cycle.
- PS and IL are sampled only in their meaningful state. IL in EXECUTE and PS in FETCH are ignored.

Test Plan:
1. Reset/fetch: pulse rst_n low for 1 cycle with RESET_PC=0x10. Then run instr_in=0x0123, imem_valid=1, IL=1, PS=01.
   - After reset: pc=0x10, state=0, ir=0.
   - After the next edge: ir=0x0123, state=1.
   - After the following edge: pc=0x11, state=0.
2. Branch sign-extend and wrap:
   - pc=0x02, ir=0xB0FC (off=-4), PS=10 -> pc=0xFF.
   - pc=0xFF, PS=01 -> pc=0x00.
3. Call/return: pc=0x20, ir=0xD005.
   - Execute -> stack[0]=0x21, sp=1, pc=0x26.
   - Later execute with PS=11 -> pc=0x21, sp=0.
4. Overflow/underflow, STACK_DEPTH=4:
   - Five consecutive calls -> sp=4, stk_ovf=1, fifth call gives pc=pc1.
   - Five returns: the first four pop in reverse order, the fifth sets stk_unf=1 and gives pc=pc1.
   - Both flags remain 1 until reset.
5. Fetch stall: hold imem_valid=0 for 3 cycles in FETCH -> state=0, pc and ir unchanged. Raise imem_valid -> ir loads on that edge.
6. Reset mid-operation: assert rst_n=0 in EXECUTE during a call with sp=2 -> next edge gives pc=RESET_PC, sp=0, state=0, no push, flags 0.
